// File: rtl/bcd_accum_display_if.sv
// rtl/bcd_accum_display_if.sv - operand/result/display bundle for the BCD accumulator
interface bcd_accum_display_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic                  mode;
    logic                  carry_in;
    logic [4*DIGITS-1:0]   operand;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   acc;
    logic                  carry_out;
    logic [6:0]            seg;
    logic [DIGITS-1:0]     an;

    modport master (
        output start, mode, carry_in, operand,
        input  busy, done, acc, carry_out, seg, an
    );

    modport slave (
        input  start, mode, carry_in, operand,
        output busy, done, acc, carry_out, seg, an
    );
endinterface

// File: rtl/bcd_accum_display.sv
// rtl/bcd_accum_display.sv - digit-serial BCD accumulator with scanned seven-segment output
module bcd_accum_display #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    bcd_accum_display_if.slave    bus
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int W  = 4 * DIGITS;

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    op_q, op_d;
    logic            c_q, c_d;
    logic            cout_q, cout_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   scan_q, scan_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic [4:0]      sum;
    logic [4:0]      sum_adj;

    function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < DIGITS; i++)
            r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
        return r;
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0011000;
            default: seg_code = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            op_q    <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            scan_q  <= '0;
            an_q    <= ~DIGITS'(1);
            seg_q   <= 7'b1000000;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            scan_q  <= scan_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        c_d     = c_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
        sum     = '0;
        sum_adj = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.mode) begin
                        acc_d   = clamp_bcd(bus.operand);
                        cout_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        op_d    = clamp_bcd(bus.operand);
                        c_d     = bus.carry_in;
                        idx_d   = '0;
                        state_d = S_ADD;
                    end
                end
            end
            S_ADD: begin
                sum     = {1'b0, acc_q[{idx_q, 2'b00} +: 4]} + {1'b0, op_q[{idx_q, 2'b00} +: 4]} + {4'b0, c_q};
                sum_adj = sum - 5'd10;
                if (sum > 5'd9) begin
                    acc_d[{idx_q, 2'b00} +: 4] = sum_adj[3:0];
                    c_d = 1'b1;
                end else begin
                    acc_d[{idx_q, 2'b00} +: 4] = sum[3:0];
                    c_d = 1'b0;
                end
                if (idx_q == IW'(DIGITS - 1)) begin
                    cout_d  = (sum > 5'd9);
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Display registers are fed from next-state acc so they never lag the accumulator.
    always_comb begin
        cnt_d  = (cnt_q == CW'(REFRESH_DIV - 1)) ? '0 : cnt_q + 1'b1;
        scan_d = scan_q;
        if (cnt_q == CW'(REFRESH_DIV - 1))
            scan_d = (scan_q == IW'(DIGITS - 1)) ? '0 : scan_q + 1'b1;
        an_d  = ~(DIGITS'(1) << scan_d);
        seg_d = seg_code(acc_d[{scan_d, 2'b00} +: 4]);
    end

    always_comb begin
        bus.busy      = (state_q == S_ADD);
        bus.done      = (state_q == S_DONE);
        bus.acc       = acc_q;
        bus.carry_out = cout_q;
        bus.seg       = seg_q;
        bus.an        = an_q;
    end
endmodule

// File: tb/tb_bcd_accum_display.sv
// tb/tb_bcd_accum_display.sv - randomized bench for bcd_accum_display against a decimal model
module tb_bcd_accum_display;
    localparam int DIGITS = 4;
    localparam int RDIV   = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bcd_accum_display_if #(.DIGITS(DIGITS)) bus ();

    bcd_accum_display #(.DIGITS(DIGITS), .REFRESH_DIV(RDIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int model_acc = 0;
    int model_cout = 0;
    int edges;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};

    always @(posedge clk or posedge reset)
        if (reset) edges <= 0;
        else       edges <= edges + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clampd(input logic [3:0] d);
        return (d > 4'd9) ? 9 : int'(d);
    endfunction

    function automatic int bcd2int(input logic [15:0] v);
        return clampd(v[3:0]) + 10 * clampd(v[7:4]) + 100 * clampd(v[11:8]) + 1000 * clampd(v[15:12]);
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    task automatic do_load(input logic [15:0] op);
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 1'b1; bus.operand = op;
        @(posedge clk); #1;
        bus.start = 1'b0;
        model_acc  = bcd2int(op);
        model_cout = 0;
        @(negedge clk);
        check("load_done", bus.done, 1);
        check("load_busy", bus.busy, 0);
        check("load_acc", bus.acc, int2bcd(model_acc));
        check("load_cout", bus.carry_out, 0);
        @(negedge clk);
        check("load_done_low", bus.done, 0);
    endtask

    task automatic do_add(input logic [15:0] op, input bit cin, input bit poke);
        int s, exp_d0, busy_n, done_n, done_at;
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 1'b0; bus.operand = op; bus.carry_in = cin;
        @(posedge clk); #1;
        bus.start = 1'b0;
        exp_d0     = (model_acc % 10 + clampd(op[3:0]) + int'(cin)) % 10;
        s          = model_acc + bcd2int(op) + int'(cin);
        model_cout = (s >= 10000) ? 1 : 0;
        model_acc  = s % 10000;
        busy_n = 0; done_n = 0; done_at = -1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (bus.busy) busy_n++;
            if (bus.done) begin
                done_n++;
                if (done_at < 0) done_at = j;
            end
            if (j == 1) check("mid_digit0", bus.acc[3:0], exp_d0);
            if (poke && j == 1) begin
                bus.start = 1'b1; bus.mode = 1'($urandom_range(0, 1)); bus.operand = 16'($urandom);
            end
            if (poke && j == 2) bus.start = 1'b0;
        end
        check("add_busy_cycles", busy_n, DIGITS);
        check("add_done_count", done_n, 1);
        check("add_done_at", done_at, DIGITS);
        check("add_acc", bus.acc, int2bcd(model_acc));
        check("add_cout", bus.carry_out, model_cout);
    endtask

    task automatic check_display(input int n);
        int scan, digit;
        logic [3:0] exp_an;
        repeat (n) begin
            @(negedge clk);
            scan   = (edges / RDIV) % DIGITS;
            digit  = (model_acc / (10 ** scan)) % 10;
            exp_an = ~(4'b0001 << scan);
            check("an", bus.an, exp_an);
            check("seg", bus.seg, seg_tab[digit]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.mode = 1'b0; bus.carry_in = 1'b0; bus.operand = '0;
        #12;
        check("rst_acc", bus.acc, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_cout", bus.carry_out, 0);
        check("rst_an", bus.an, 4'b1110);
        check("rst_seg", bus.seg, 7'b1000000);
        @(negedge clk);
        reset = 1'b0;

        do_load(16'h1234);
        check_display(20);
        do_add(16'h0999, 1'b1, 1'b0);
        check("t2_acc", bus.acc, 16'h2234);

        do_load(16'h9999);
        do_add(16'h0001, 1'b0, 1'b0);
        check("t3_wrap_acc", bus.acc, 16'h0000);
        check("t3_wrap_cout", bus.carry_out, 1);
        do_load(16'h0005);

        do_load(16'hABCF);
        check("t4_clamp", bus.acc, 16'h9999);
        do_load(16'h0000);
        do_add(16'h00F0, 1'b0, 1'b0);
        check("t4_add_clamp", bus.acc, 16'h0090);

        do_load(16'h1234);
        do_add(16'h4321, 1'b1, 1'b1);

        @(negedge clk);
        bus.start = 1'b1; bus.mode = 1'b0; bus.operand = 16'h5555; bus.carry_in = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_acc", bus.acc, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_done", bus.done, 0);
        check("arst_cout", bus.carry_out, 0);
        model_acc = 0; model_cout = 0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("arst_idle_done", bus.done, 0);
        check("arst_idle_busy", bus.busy, 0);

        for (int n = 0; n < 40; n++) begin
            logic [15:0] op;
            if ($urandom_range(0, 3) == 0) op = 16'($urandom);
            else                           op = int2bcd($urandom_range(0, 9999));
            if ($urandom_range(0, 2) == 0) do_load(op);
            else                           do_add(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        check_display(12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
